// File: rtl/pwm_timer_scheduler_if.sv
// rtl/pwm_timer_scheduler_if.sv - request/grant bundle between requesters and the shared PWM timer
interface pwm_timer_scheduler_if #(
  parameter int N = 8
);
  logic           tick_en;
  logic [3:0]     req;
  logic [4*N-1:0] req_value;
  logic [3:0]     grant;
  logic           busy;
  logic [3:0]     done;
  logic [N-1:0]   count;

  modport master (
    output tick_en, req, req_value,
    input  grant, busy, done, count
  );

  modport slave (
    input  tick_en, req, req_value,
    output grant, busy, done, count
  );
endinterface

// File: rtl/pwm_timer_scheduler.sv
// rtl/pwm_timer_scheduler.sv - round-robin owner of one shared up-counter across four requesters
module pwm_timer_scheduler #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  pwm_timer_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t       state_q, state_n;
  logic [3:0]   grant_q, grant_n;
  logic [3:0]   done_q, done_n;
  logic         busy_q, busy_n;
  logic [N-1:0] count_q, count_n;
  logic [N-1:0] val_q, val_n;
  logic [1:0]   last_q, last_n;
  logic [1:0]   win_q, win_n;

  logic         rr_hit;
  logic [1:0]   rr_idx;
  logic [1:0]   cand;

  // Search starts just after the most recent owner so the previous winner goes last.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = last_q;
    cand   = '0;
    for (int k = 0; k < 4; k++) begin
      cand = last_q + 2'(k + 1);
      if (!rr_hit && bus.req[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    done_n  = '0;
    count_n = count_q;
    val_n   = val_q;
    last_n  = last_q;
    win_n   = win_q;
    case (state_q)
      IDLE: begin
        if (rr_hit) begin
          win_n   = rr_idx;
          val_n   = bus.req_value[rr_idx*N +: N];
          count_n = '0;
          grant_n = 4'b0001 << rr_idx;
          state_n = COUNT;
        end
      end
      COUNT: begin
        // Losing the request wins over a completion landing in the same cycle.
        if (!bus.req[win_q]) begin
          state_n = IDLE;
          grant_n = '0;
          count_n = '0;
          last_n  = win_q;
        end else if (bus.tick_en) begin
          if (count_q == val_q) begin
            state_n = DONE;
            grant_n = '0;
            done_n  = grant_q;
            last_n  = win_q;
          end else begin
            count_n = count_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
    busy_n = |grant_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      val_q   <= '0;
      last_q  <= 2'd3;
      win_q   <= '0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
      count_q <= count_n;
      val_q   <= val_n;
      last_q  <= last_n;
      win_q   <= win_n;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_pwm_timer_scheduler.sv
// tb/tb_pwm_timer_scheduler.sv - scoreboard bench for pwm_timer_scheduler
module tb_pwm_timer_scheduler;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pwm_timer_scheduler_if #(.N(N)) bus ();
  pwm_timer_scheduler #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic         rst;
    logic         tick;
    logic [3:0]   req;
    logic [N-1:0] v0;
    logic [3:0]   eg;
    logic [3:0]   ed;
    logic [N-1:0] ec;
  } vec_t;

  typedef struct {
    logic [3:0]   g;
    logic [3:0]   d;
    logic [N-1:0] c;
    string        name;
  } exp_t;

  vec_t tbl [8];
  exp_t sb_q [$];
  logic [3:0] rr_q [$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           m_st = 0;
  logic [1:0]   m_w = '0;
  logic [1:0]   m_last = 2'd3;
  logic [N-1:0] m_val = '0;
  logic [N-1:0] m_cnt = '0;
  logic [3:0]   m_g = '0;
  logic [3:0]   m_d = '0;

  // Observation state kept by the monitor
  int         cyc = 0;
  int         grant_cyc = 0;
  int         done_delta = 0;
  int         done_cnt = 0;
  logic [N-1:0] max_cnt = '0;
  logic [3:0] prev_grant = '0;
  logic       rec_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic t, input logic [3:0] q,
                            input logic [4*N-1:0] v);
    bit found;
    int i;
    m_d = '0;
    if (r) begin
      m_st = 0; m_g = '0; m_cnt = '0; m_last = 2'd3;
    end else begin
      case (m_st)
        0: begin
          found = 0;
          for (int k = 1; k <= 4; k++) begin
            i = (int'(m_last) + k) % 4;
            if (!found && q[i]) begin
              found = 1;
              m_w   = 2'(i);
              m_val = v[i*N +: N];
              m_cnt = '0;
              m_g   = 4'b0001 << i;
              m_st  = 1;
            end
          end
        end
        1: begin
          if (!q[m_w]) begin
            m_st = 0; m_g = '0; m_cnt = '0; m_last = m_w;
          end else if (t) begin
            if (m_cnt == m_val) begin
              m_st = 2; m_d = m_g; m_g = '0; m_last = m_w;
            end else begin
              m_cnt = m_cnt + 1'b1;
            end
          end
        end
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic drive(input logic r, input logic t, input logic [3:0] q,
                       input logic [4*N-1:0] v, input string nm, input bit use_exp,
                       input logic [3:0] eg, input logic [3:0] ed, input logic [N-1:0] ec);
    exp_t e;
    @(negedge clk);
    reset = r; bus.tick_en = t; bus.req = q; bus.req_value = v;
    model_step(r, t, q, v);
    e.name = nm;
    if (use_exp) begin
      e.g = eg; e.d = ed; e.c = ec;
    end else begin
      e.g = m_g; e.d = m_d; e.c = m_cnt;
    end
    sb_q.push_back(e);
  endtask

  task automatic run(input logic r, input logic t, input logic [3:0] q,
                     input logic [4*N-1:0] v, input string nm);
    drive(r, t, q, v, nm, 1'b0, '0, '0, '0);
  endtask

  // Parks the block by dropping every request, then confirms all expectations were consumed.
  task automatic drain();
    @(negedge clk);
    bus.req = '0; bus.tick_en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.name, "_grant"}, bus.grant, e.g);
        chk({e.name, "_done"},  bus.done,  e.d);
        chk({e.name, "_count"}, bus.count, e.c);
        chk({e.name, "_busy"},  bus.busy,  |e.g);
      end
      if (bus.done != 4'b0000) begin
        chk("done_onehot", $onehot(bus.done), 1);
        chk("done_is_prev_grant", bus.done, prev_grant);
        done_cnt++;
        done_delta = cyc - grant_cyc;
      end
      if (bus.grant != 4'b0000 && prev_grant == 4'b0000) begin
        grant_cyc = cyc;
        if (rec_en && rr_q.size() < 5) rr_q.push_back(bus.grant);
      end
      if (bus.count > max_cnt) max_cnt = bus.count;
      prev_grant = bus.grant;
    end
  end

  initial begin
    int base;
    logic [3:0] rq;
    logic [4*N-1:0] rv;
    reset = 1'b1; bus.tick_en = 1'b0; bus.req = '0; bus.req_value = '0;

    tbl[0] = '{1'b1, 1'b1, 4'b0000, 8'd3, 4'b0000, 4'b0000, 8'd0};
    tbl[1] = '{1'b0, 1'b1, 4'b0001, 8'd3, 4'b0001, 4'b0000, 8'd0};
    tbl[2] = '{1'b0, 1'b1, 4'b0001, 8'd3, 4'b0001, 4'b0000, 8'd1};
    tbl[3] = '{1'b0, 1'b1, 4'b0001, 8'd3, 4'b0001, 4'b0000, 8'd2};
    tbl[4] = '{1'b0, 1'b1, 4'b0001, 8'd3, 4'b0001, 4'b0000, 8'd3};
    tbl[5] = '{1'b0, 1'b1, 4'b0001, 8'd3, 4'b0000, 4'b0001, 8'd3};
    tbl[6] = '{1'b0, 1'b1, 4'b0000, 8'd3, 4'b0000, 4'b0000, 8'd3};
    tbl[7] = '{1'b0, 1'b1, 4'b0000, 8'd3, 4'b0000, 4'b0000, 8'd3};
    for (int i = 0; i < 8; i++)
      drive(tbl[i].rst, tbl[i].tick, tbl[i].req, {{(3*N){1'b0}}, tbl[i].v0},
            "single", 1'b1, tbl[i].eg, tbl[i].ed, tbl[i].ec);
    drain();

    // Abort: requester 0 drops at count 1, pending requester 1 follows
    rv = {8'd0, 8'd0, 8'd2, 8'd5};
    run(1'b1, 1'b1, 4'b0000, rv, "abort_rst");
    run(1'b0, 1'b1, 4'b0001, rv, "abort");
    run(1'b0, 1'b1, 4'b0001, rv, "abort");
    base = done_cnt;
    drive(1'b0, 1'b1, 4'b0010, rv, "abort_drop", 1'b1, 4'b0000, 4'b0000, 8'd0);
    drive(1'b0, 1'b1, 4'b0010, rv, "abort_next", 1'b1, 4'b0010, 4'b0000, 8'd0);
    repeat (3) run(1'b0, 1'b1, 4'b0010, rv, "abort");
    run(1'b0, 1'b1, 4'b0000, rv, "abort");
    drain();
    chk("abort_done_count", done_cnt - base, 1);

    // Reset in the middle of a count
    rv = {8'd1, 8'd0, 8'd0, 8'd9};
    run(1'b1, 1'b1, 4'b0000, rv, "rstmid_rst");
    repeat (6) run(1'b0, 1'b1, 4'b0001, rv, "rstmid");
    base = done_cnt;
    drive(1'b1, 1'b1, 4'b0001, rv, "rstmid_hit", 1'b1, 4'b0000, 4'b0000, 8'd0);
    drive(1'b0, 1'b1, 4'b1001, rv, "rstmid_prio", 1'b1, 4'b0001, 4'b0000, 8'd0);
    drain();
    chk("rstmid_no_done", done_cnt - base, 1 - 1);

    // Round-robin with every requester active and zero durations
    run(1'b1, 1'b1, 4'b0000, '0, "rr_rst");
    base = done_cnt;
    rr_q.delete();
    rec_en = 1'b1;
    repeat (16) run(1'b0, 1'b1, 4'b1111, '0, "rr");
    drain();
    rec_en = 1'b0;
    chk("rr_len", rr_q.size(), 5);
    if (rr_q.size() == 5) begin
      chk("rr_0", rr_q[0], 4'b0001);
      chk("rr_1", rr_q[1], 4'b0010);
      chk("rr_2", rr_q[2], 4'b0100);
      chk("rr_3", rr_q[3], 4'b1000);
      chk("rr_4", rr_q[4], 4'b0001);
    end
    chk("rr_done_count", done_cnt - base, 5);

    // Gated tick: one tick every fourth cycle
    rv = {8'd0, 8'd0, 8'd0, 8'd2};
    run(1'b1, 1'b1, 4'b0000, rv, "gate_rst");
    base = done_cnt;
    for (int i = 0; i < 20; i++) run(1'b0, (i % 4) == 3, 4'b0001, rv, "gate");
    drain();
    chk("gate_done_count", done_cnt - base, 1);
    chk("gate_done_delay", done_delta, 11);

    // Full-range duration
    rv = {8'd0, 8'd0, 8'd0, 8'd255};
    run(1'b1, 1'b1, 4'b0000, rv, "max_rst");
    max_cnt = '0;
    repeat (260) run(1'b0, 1'b1, 4'b0001, rv, "max");
    drain();
    chk("max_count_peak", max_cnt, 8'd255);
    chk("max_done_delay", done_delta, 256);

    // Random traffic against the model
    run(1'b1, 1'b1, 4'b0000, '0, "rand_rst");
    rq = 4'b0000;
    rv = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        rv[$urandom_range(0, 3)*N +: N] = N'($urandom_range(0, 6));
      run($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)), rq, rv, "rand");
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
